// File: rtl/lampFPU_pkg.sv
// Shared definitions for the lampFPU square-root unit.
//   state_t          : FSM state encoding (IDLE, SPECIAL, CALC, ROUND, DONE)
//   exp_ones(e_dw)   : all-ones exponent field (inf / qNaN exponent)
//   qnan_frac(f_dw)  : quiet-NaN fraction field (MSB set, rest clear)
//   inf_frac(f_dw)   : infinity fraction field (all clear)
// The helpers return 32-bit values; callers size-cast to the field width.
package lampFPU_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE    = 3'd0;
   localparam state_t SPECIAL = 3'd1;
   localparam state_t CALC    = 3'd2;
   localparam state_t ROUND   = 3'd3;
   localparam state_t DONE    = 3'd4;

   function automatic logic [31:0] exp_ones(input int unsigned e_dw);
      return (32'd1 << e_dw) - 32'd1;
   endfunction

   function automatic logic [31:0] qnan_frac(input int unsigned f_dw);
      return 32'd1 << (f_dw - 1);
   endfunction

   function automatic logic [31:0] inf_frac(input int unsigned f_dw);
      return (f_dw > 32) ? 32'd0 : 32'd0;
   endfunction

endpackage

// File: rtl/lampFPU_sqrt_core.sv
// Restoring radix-2 square-root recurrence, one root bit per step.
//   clk, rst : clock, synchronous active-high reset (clears all registers)
//   load     : capture radicand significand, clear root/remainder/counter
//   step     : perform one recurrence iteration
//   rad      : radicand significand, F_DW+2 bits (2 integer bits)
//   root     : root bits below the integer bit (F_DW fraction + guard)
//   rem_nz   : partial remainder is nonzero (sticky)
//   last     : the current step is the final one (F_DW+2 steps total)
module lampFPU_sqrt_core #(
   parameter int unsigned F_DW = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [F_DW+1:0] rad,
   output logic [F_DW:0]   root,
   output logic            rem_nz,
   output logic            last
);

   localparam int unsigned QW = F_DW + 2;      // root width
   localparam int unsigned RW = F_DW + 5;      // remainder width
   localparam int unsigned XW = 2 * F_DW + 4;  // padded radicand width
   localparam int unsigned CW = $clog2(F_DW + 3);

   logic [XW-1:0] rad_q;
   logic [RW-1:0] rem_q;
   logic [QW-1:0] root_q;
   logic [CW-1:0] cnt_q;

   logic [RW-1:0] rem_sh;
   logic [RW-1:0] trial;
   logic [RW-1:0] diff;
   logic          ge;

   // Bring down the next radicand digit pair and try subtracting 4*root+1.
   always_comb begin
      rem_sh = {rem_q[RW-3:0], rad_q[XW-1 -: 2]};
      trial  = {1'b0, root_q, 2'b01};
      diff   = rem_sh - trial;
      ge     = (rem_sh >= trial);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         // Pad so that the integer root carries F_DW+1 fractional bits.
         rad_q  <= {rad, {(F_DW + 2){1'b0}}};
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
      end else if (step) begin
         rad_q  <= rad_q << 2;
         rem_q  <= ge ? diff : rem_sh;
         root_q <= {root_q[QW-2:0], ge};
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign root   = root_q[QW-2:0];
   assign rem_nz = |rem_q;
   assign last   = (cnt_q == CW'(F_DW + 1));

endmodule

// File: rtl/lampfpu_sqrt_iter.sv
// Iterative floating-point square root (denormals flushed to zero, RNE).
//   clk, rst          : clock, synchronous active-high reset
//   doSqrt_i          : start request, accepted only while busy_o is low
//   s_op_i/e_op_i/f_op_i : operand sign, biased exponent, stored fraction
//   busy_o            : operation in flight, through the valid cycle
//   valid_o           : one-cycle result pulse
//   s_res_o/e_res_o/f_res_o : registered result fields, held until next valid
//   isInv_o/isNaN_o/isInexact_o : registered result flags
// Specials finish one cycle after accept; normals after F_DW+4 cycles.
module lampfpu_sqrt_iter
   import lampFPU_pkg::*;
#(
   parameter int unsigned E_DW = 8,
   parameter int unsigned F_DW = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            doSqrt_i,
   input  logic            s_op_i,
   input  logic [E_DW-1:0] e_op_i,
   input  logic [F_DW-1:0] f_op_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic            s_res_o,
   output logic [E_DW-1:0] e_res_o,
   output logic [F_DW-1:0] f_res_o,
   output logic            isInv_o,
   output logic            isNaN_o,
   output logic            isInexact_o
);

   localparam int unsigned BIAS = (1 << (E_DW - 1)) - 1;
   localparam logic signed [E_DW+1:0] BIAS_S = (E_DW + 2)'(BIAS);
   localparam logic [E_DW-1:0] EXP_ONES  = E_DW'(exp_ones(E_DW));
   localparam logic [F_DW-1:0] QNAN_F    = F_DW'(qnan_frac(F_DW));
   localparam logic [F_DW-1:0] INF_F     = F_DW'(inf_frac(F_DW));

   state_t state, state_nxt;

   logic accept;
   logic is_zero, is_emax, is_nan, special;

   logic            sp_s, sp_inv, sp_nan;
   logic [E_DW-1:0] sp_e;
   logic [F_DW-1:0] sp_f;

   logic signed [E_DW+1:0] e_unb, e_adj, e_half;
   logic [E_DW-1:0]        e_calc_nxt, e_calc;
   logic [F_DW+1:0]        rad;

   logic [F_DW:0]   root;
   logic            rem_nz, last;
   logic            guard, round_up, carry;
   logic [F_DW-1:0] f_rnd;

   assign accept = doSqrt_i & ~busy_o;

   // Operand classification.
   always_comb begin
      is_zero = (e_op_i == '0);
      is_emax = (e_op_i == '1);
      is_nan  = is_emax && (f_op_i != '0);
      // Negative non-zero operands are invalid and also resolve immediately.
      special = is_zero | is_emax | s_op_i;
   end

   // Special-case result fields.
   always_comb begin
      sp_s   = 1'b0;
      sp_e   = '0;
      sp_f   = '0;
      sp_inv = 1'b0;
      sp_nan = 1'b0;
      if (is_zero) begin
         sp_s = s_op_i;
      end else if (is_nan) begin
         sp_e   = EXP_ONES;
         sp_f   = QNAN_F;
         sp_nan = 1'b1;
      end else if (s_op_i) begin
         sp_e   = EXP_ONES;
         sp_f   = QNAN_F;
         sp_inv = 1'b1;
         sp_nan = 1'b1;
      end else begin
         sp_e = EXP_ONES;
         sp_f = INF_F;
      end
   end

   // Exponent halving; odd unbiased exponents borrow one into the significand.
   always_comb begin
      e_unb      = $signed({2'b00, e_op_i}) - BIAS_S;
      e_adj      = e_unb - $signed({{(E_DW + 1){1'b0}}, e_unb[0]});
      e_half     = e_adj >>> 1;
      e_calc_nxt = E_DW'(e_half + BIAS_S);
      rad        = e_unb[0] ? {1'b1, f_op_i, 1'b0} : {2'b01, f_op_i};
   end

   lampFPU_sqrt_core #(
      .F_DW (F_DW)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept & ~special),
      .step   (state == CALC),
      .rad    (rad),
      .root   (root),
      .rem_nz (rem_nz),
      .last   (last)
   );

   // Round to nearest even on the root fraction; integer bit is always 1,
   // so a carry out of the fraction means the root reached 2.0.
   always_comb begin
      guard           = root[0];
      round_up        = guard & (rem_nz | root[1]);
      {carry, f_rnd}  = {1'b0, root[F_DW:1]} + (F_DW + 1)'(round_up);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? SPECIAL : CALC;
         SPECIAL: state_nxt = IDLE;
         CALC:    if (last) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy_o      <= 1'b0;
         valid_o     <= 1'b0;
         s_res_o     <= 1'b0;
         e_res_o     <= '0;
         f_res_o     <= '0;
         isInv_o     <= 1'b0;
         isNaN_o     <= 1'b0;
         isInexact_o <= 1'b0;
         e_calc      <= '0;
      end else begin
         state   <= state_nxt;
         busy_o  <= (state_nxt != IDLE);
         valid_o <= (state_nxt == SPECIAL) || (state_nxt == DONE);
         if (accept && special) begin
            s_res_o     <= sp_s;
            e_res_o     <= sp_e;
            f_res_o     <= sp_f;
            isInv_o     <= sp_inv;
            isNaN_o     <= sp_nan;
            isInexact_o <= 1'b0;
         end
         if (accept && !special) begin
            e_calc <= e_calc_nxt;
         end
         if (state == ROUND) begin
            s_res_o     <= 1'b0;
            e_res_o     <= e_calc + E_DW'(carry);
            f_res_o     <= f_rnd;
            isInv_o     <= 1'b0;
            isNaN_o     <= 1'b0;
            isInexact_o <= guard | rem_nz;
         end
      end
   end

endmodule

// File: tb/tb_lampfpu_sqrt_iter.sv
// Self-checking bench for lampfpu_sqrt_iter at default widths (8/7).
module tb_lampfpu_sqrt_iter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       doSqrt_i = 1'b0;
   logic       s_op_i = 1'b0;
   logic [7:0] e_op_i = '0;
   logic [6:0] f_op_i = '0;
   logic       busy_o, valid_o, s_res_o, isInv_o, isNaN_o, isInexact_o;
   logic [7:0] e_res_o;
   logic [6:0] f_res_o;
   logic [15:0] res_w;

   int n_checks = 0;
   int n_fail   = 0;

   assign res_w = {s_res_o, e_res_o, f_res_o};

   lampfpu_sqrt_iter #(
      .E_DW (8),
      .F_DW (7)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .doSqrt_i    (doSqrt_i),
      .s_op_i      (s_op_i),
      .e_op_i      (e_op_i),
      .f_op_i      (f_op_i),
      .busy_o      (busy_o),
      .valid_o     (valid_o),
      .s_res_o     (s_res_o),
      .e_res_o     (e_res_o),
      .f_res_o     (f_res_o),
      .isInv_o     (isInv_o),
      .isNaN_o     (isNaN_o),
      .isInexact_o (isInexact_o)
   );

   always #5 clk = ~clk;

   // Reference: exact integer square root of the scaled significand,
   // then round-to-nearest-even on the 8-bit significand.
   function automatic void ref_sqrt(input logic [15:0] op, output logic [15:0] r,
                                    output logic [2:0] flags, output int lat);
      int e, ex, m, q, sig, er;
      longint x;
      logic s;
      logic [7:0] ee;
      logic [6:0] ff;
      logic g, st, up;
      s = op[15]; ee = op[14:7]; ff = op[6:0];
      flags = 3'b000; lat = 1;
      if (ee == 8'd0) begin
         r = {s, 15'd0};
      end else if (ee == 8'hFF && ff != 7'd0) begin
         r = 16'h7FC0; flags = 3'b010;
      end else if (s) begin
         r = 16'h7FC0; flags = 3'b110;
      end else if (ee == 8'hFF) begin
         r = 16'h7F80;
      end else begin
         lat = 11;
         e = int'(ee) - 127;
         m = 128 + int'(ff);
         if (e % 2 == 0) begin x = longint'(m) << 9;  ex = e / 2; end
         else            begin x = longint'(m) << 10; ex = (e - 1) / 2; end
         q = 0;
         while (longint'(q + 1) * longint'(q + 1) <= x) q++;
         st  = (longint'(q) * longint'(q) != x);
         g   = q[0];
         sig = q >> 1;
         up  = g && (st || sig[0]);
         sig = sig + int'(up);
         er  = ex + 127;
         if (sig == 256) begin sig = 128; er = er + 1; end
         r = {1'b0, er[7:0], sig[6:0]};
         flags = {2'b00, g | st};
      end
   endfunction

   // Drive a request in one cycle; afterwards scramble the operand inputs.
   task automatic issue(input logic [15:0] op);
      @(negedge clk);
      doSqrt_i = 1'b1;
      {s_op_i, e_op_i, f_op_i} = op;
      @(posedge clk);
      #1;
      doSqrt_i = 1'b0;
      {s_op_i, e_op_i, f_op_i} = 16'($urandom);
   endtask

   // Cycle-bounded wait for valid_o; lat = -1 if it never came.
   task automatic wait_valid(input int max_cyc, output int lat, output logic busy_ok);
      lat = -1;
      busy_ok = 1'b1;
      for (int n = 1; n <= max_cyc; n++) begin
         @(negedge clk);
         if (busy_o !== 1'b1) busy_ok = 1'b0;
         if (valid_o === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      doSqrt_i = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy_o, valid_o, res_w, isInv_o, isNaN_o, isInexact_o} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0", {busy_o, valid_o, res_w, isInv_o, isNaN_o, isInexact_o});
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy_o, valid_o, res_w, isInv_o, isNaN_o, isInexact_o} !== 21'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %h required 0", {busy_o, valid_o, res_w, isInv_o, isNaN_o, isInexact_o});
      end
   endtask

   task automatic test_directed();
      logic [15:0] ops [7]  = '{16'h4080, 16'h4100, 16'h4000, 16'hBF80, 16'h7F80, 16'h8000, 16'h0001};
      logic [15:0] exps [7] = '{16'h4000, 16'h4035, 16'h3FB5, 16'h7FC0, 16'h7F80, 16'h8000, 16'h0000};
      logic [2:0]  flg [7]  = '{3'b000, 3'b001, 3'b001, 3'b110, 3'b000, 3'b000, 3'b000};
      int          lats [7] = '{11, 11, 11, 1, 1, 1, 1};
      int lat;
      logic bok;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i]);
         wait_valid(20, lat, bok);
         n_checks++;
         if (lat != lats[i]) begin
            n_fail++;
            $display("FAIL dir_latency op=%h: got %0d required %0d", ops[i], lat, lats[i]);
         end
         n_checks++;
         if (res_w !== exps[i] || {isInv_o, isNaN_o, isInexact_o} !== flg[i]) begin
            n_fail++;
            $display("FAIL dir_result op=%h: got %h flags %b required %h flags %b",
                     ops[i], res_w, {isInv_o, isNaN_o, isInexact_o}, exps[i], flg[i]);
         end
         n_checks++;
         if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_busy op=%h: got busy low before valid required high", ops[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] op, er;
      logic [2:0]  ef;
      int elat, lat;
      logic bok;
      for (int i = 0; i < 60; i++) begin
         op = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       op[14:7] = 8'h00;
            1:       op[14:7] = 8'hFF;
            2, 3, 4: op[15]   = 1'b0;
            default: ;
         endcase
         ref_sqrt(op, er, ef, elat);
         issue(op);
         wait_valid(20, lat, bok);
         n_checks++;
         if (lat != elat || res_w !== er || {isInv_o, isNaN_o, isInexact_o} !== ef) begin
            n_fail++;
            $display("FAIL rand op=%h: got %h flags %b lat %0d required %h flags %b lat %0d",
                     op, res_w, {isInv_o, isNaN_o, isInexact_o}, lat, er, ef, elat);
         end
      end
   endtask

   task automatic test_hold();
      logic [15:0] er;
      logic [2:0]  ef;
      int elat, lat;
      logic bok;
      ref_sqrt(16'h3F00, er, ef, elat);
      issue(16'h3F00);
      wait_valid(20, lat, bok);
      repeat (3) @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || res_w !== er || {isInv_o, isNaN_o, isInexact_o} !== ef) begin
         n_fail++;
         $display("FAIL hold: got v=%b b=%b %h %b required v=0 b=0 %h %b",
                  valid_o, busy_o, res_w, {isInv_o, isNaN_o, isInexact_o}, er, ef);
      end
   endtask

   task automatic test_back_to_back();
      int vcnt = 0;
      int vat = -1;
      logic [15:0] r11 = '0;
      issue(16'h4080);
      for (int n = 1; n <= 11; n++) begin
         @(negedge clk);
         if (n == 3) begin
            doSqrt_i = 1'b1;
            {s_op_i, e_op_i, f_op_i} = 16'h7F80;
         end
         if (n == 4) doSqrt_i = 1'b0;
         if (valid_o === 1'b1) begin
            vcnt++;
            vat = n;
            r11 = res_w;
         end
      end
      n_checks++;
      if (vcnt != 1 || vat != 11 || r11 !== 16'h4000) begin
         n_fail++;
         $display("FAIL busy_ignore: got %0d valids last at %0d res %h required 1 at 11 res 4000", vcnt, vat, r11);
      end
      // Cycle T+12: idle again, a new request must be taken immediately.
      @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: got busy %b valid %b required 0 0", busy_o, valid_o);
      end
      doSqrt_i = 1'b1;
      {s_op_i, e_op_i, f_op_i} = 16'h7F80;
      @(posedge clk);
      #1;
      doSqrt_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (valid_o !== 1'b1 || res_w !== 16'h7F80) begin
         n_fail++;
         $display("FAIL b2b_accept: got valid %b res %h required 1 7f80", valid_o, res_w);
      end
   endtask

   task automatic test_reset_mid();
      int vcnt = 0;
      int lat;
      logic bok;
      issue(16'h4100);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         if (valid_o === 1'b1) vcnt++;
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_o, valid_o, res_w, isInv_o, isNaN_o, isInexact_o} !== 21'd0) begin
         n_fail++;
         $display("FAIL mid_reset_clear: got %h required 0", {busy_o, valid_o, res_w, isInv_o, isNaN_o, isInexact_o});
      end
      rst = 1'b0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (valid_o === 1'b1 || busy_o === 1'b1) vcnt++;
      end
      n_checks++;
      if (vcnt != 0) begin
         n_fail++;
         $display("FAIL mid_reset_abort: got %0d valid/busy cycles required 0", vcnt);
      end
      issue(16'h4080);
      wait_valid(20, lat, bok);
      n_checks++;
      if (lat != 11 || res_w !== 16'h4000 || isInexact_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_recover: got %h lat %0d inx %b required 4000 lat 11 inx 0", res_w, lat, isInexact_o);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
